// File: rtl/mac_result_drain_pkg.sv
// Shared constants and helpers for the MAC result drain.
// Mode encodings, beats-per-frame constants and the acc-select bit position.
// Combinational helpers only; no state lives here.
package mac_result_drain_pkg;

   // Default datapath geometry of the MAC tile
   localparam int MAC_MIN_W       = 8;
   localparam int MAC_ACC_W       = 48;
   localparam int MAC_CONF_W      = 3;
   localparam int MAC_DRAIN_DEPTH = 4;

   // Operating modes carried in issue_cfg[1:0]
   localparam logic [1:0] MAC_SINGLE    = 2'b00;
   localparam logic [1:0] MAC_DUAL      = 2'b01;
   localparam logic [1:0] MAC_QUAD      = 2'b10;
   localparam logic [1:0] MAC_MODE_NONE = 2'b11;

   // Beats per frame for non-accumulated results
   localparam int MAC_BEATS_SINGLE = 2;
   localparam int MAC_BEATS_DUAL   = 3;
   localparam int MAC_BEATS_QUAD   = 5;

   // One tag-pipe stage: whether this issue will capture, and the cfg it carries
   typedef struct packed {
      logic       cap;
      logic [1:0] mode;
      logic       acc;
   } tag_t;

   // The acc-select flag is the top bit of issue_cfg
   function automatic int mac_acc_bit(input int conf_w);
      return conf_w - 1;
   endfunction

   // Number of MIN_W beats needed to send one captured result
   function automatic int mac_beats(input logic [1:0] mode, input logic acc, input int nb_full);
      int nb;
      nb = 1;
      if (acc) begin
         nb = nb_full;
      end else begin
         case (mode)
            MAC_SINGLE: nb = MAC_BEATS_SINGLE;
            MAC_DUAL:   nb = MAC_BEATS_DUAL;
            MAC_QUAD:   nb = (nb_full < MAC_BEATS_QUAD) ? nb_full : MAC_BEATS_QUAD;
            default:    nb = 1;
         endcase
      end
      return nb;
   endfunction

endpackage

// File: rtl/mac_drain_fifo.sv
// Synchronous FIFO holding captured MAC results with an occupancy count.
// Latency: pushed entry visible at rdata_o the cycle after the push.
// Backpressure: push on full is ignored unless a pop happens in the same cycle.
module mac_drain_fifo
   import mac_result_drain_pkg::*;
#(
   parameter int W     = MAC_ACC_W + 3,
   parameter int DEPTH = MAC_DRAIN_DEPTH
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     push_i,
   input  logic [W-1:0]             wdata_i,
   input  logic                     pop_i,
   output logic [W-1:0]             rdata_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   count_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          do_push;
   logic          do_pop;

   // Qualify requests: a full FIFO still accepts a push when it is popped together
   always_comb begin
      do_pop   = pop_i & (count_q != '0);
      do_push  = push_i & ((count_q != CW'(DEPTH)) | do_pop);
      wr_ptr_d = wr_ptr_q + AW'(do_push);
      rd_ptr_d = rd_ptr_q + AW'(do_pop);
      count_d  = count_q;
      if (do_push && !do_pop) begin
         count_d = count_q + CW'(1);
      end else if (do_pop && !do_push) begin
         count_d = count_q - CW'(1);
      end
   end

   // Storage array; contents need no reset because count gates visibility
   always_ff @(posedge clk_i) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= wdata_i;
      end
   end

   // Pointers and occupancy
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   assign rdata_o = mem_q[rd_ptr_q];
   assign empty_o = (count_q == '0);
   assign count_o = count_q;

endmodule

// File: rtl/mac_result_drain.sv
// Captures MAC results after LAT cycles, buffers them, and serializes LSB-beat-first.
// Latency: capture to first beat is two cycles (FIFO write, then load into shift register).
// Backpressure: credit via issue_ready_o upstream; out_ready_i stalls the beat stream with outputs held.
module mac_result_drain
   import mac_result_drain_pkg::*;
#(
   parameter int MIN_W  = MAC_MIN_W,
   parameter int ACC_W  = MAC_ACC_W,
   parameter int CONF_W = MAC_CONF_W,
   parameter int LAT    = 1,
   parameter int DEPTH  = MAC_DRAIN_DEPTH
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              issue_valid_i,
   input  logic              issue_last_i,
   input  logic [CONF_W-1:0] issue_cfg_i,
   input  logic [ACC_W-1:0]  mac_c_i,
   output logic              issue_ready_o,
   output logic              out_valid_o,
   input  logic              out_ready_i,
   output logic [MIN_W-1:0]  out_data_o,
   output logic              out_first_o,
   output logic              out_last_o,
   output logic [1:0]        out_mode_o,
   output logic              overflow_err_o
);

   localparam int NB_FULL = ACC_W / MIN_W;
   localparam int BC_W    = $clog2(NB_FULL + 1);
   localparam int ENT_W   = ACC_W + 3;
   localparam int CNT_W   = $clog2(DEPTH) + 1;
   localparam int OCC_W   = $clog2(DEPTH + LAT + 1) + 1;
   localparam int ACC_BIT = mac_acc_bit(CONF_W);

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_SEND = 1'b1;

   // ---------------- tag pipe ----------------
   tag_t tag_in;
   tag_t tag_q [LAT];
   logic [OCC_W-1:0] inflight;
   logic             cap_now;

   // Accumulating windows only produce a result on their last element
   always_comb begin
      tag_in.cap  = issue_valid_i & (~issue_cfg_i[ACC_BIT] | issue_last_i);
      tag_in.mode = issue_cfg_i[1:0];
      tag_in.acc  = issue_cfg_i[ACC_BIT];
   end

   // Delay the tag so it lines up with mac_c_i LAT cycles after issue
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < LAT; i++) begin
            tag_q[i] <= '0;
         end
      end else begin
         tag_q[0] <= tag_in;
         for (int i = 1; i < LAT; i++) begin
            tag_q[i] <= tag_q[i-1];
         end
      end
   end

   // Captures already promised by issued-but-not-yet-captured tags
   always_comb begin
      inflight = '0;
      for (int i = 0; i < LAT; i++) begin
         inflight = inflight + OCC_W'(tag_q[i].cap);
      end
   end

   assign cap_now = tag_q[LAT-1].cap;

   // ---------------- result FIFO ----------------
   logic             fifo_push;
   logic             fifo_pop;
   logic [ENT_W-1:0] fifo_rdata;
   logic             fifo_empty;
   logic [CNT_W-1:0] fifo_count;

   mac_drain_fifo #(
      .W     (ENT_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .push_i  (fifo_push),
      .wdata_i ({mac_c_i, tag_q[LAT-1].mode, tag_q[LAT-1].acc}),
      .pop_i   (fifo_pop),
      .rdata_o (fifo_rdata),
      .empty_o (fifo_empty),
      .count_o (fifo_count)
   );

   // ---------------- serializer state ----------------
   logic [0:0]       state_q, state_d;
   logic [ACC_W-1:0] shreg_q, shreg_d;
   logic [BC_W-1:0]  beat_cnt_q, beat_cnt_d;
   logic [BC_W-1:0]  nb_q, nb_d;
   logic [1:0]       mode_q, mode_d;
   logic             overflow_q, overflow_d;

   logic [ACC_W-1:0] head_c;
   logic [1:0]       head_mode;
   logic             head_acc;
   logic [ACC_W-1:0] ld_data;
   logic [BC_W-1:0]  ld_nb;
   logic             busy;
   logic             last_beat;
   logic             frame_done;
   logic [OCC_W-1:0] occ;
   logic             drop;

   // Decode the FIFO head into what the shift register will be loaded with
   always_comb begin
      head_c    = fifo_rdata[ENT_W-1:3];
      head_mode = fifo_rdata[2:1];
      head_acc  = fifo_rdata[0];
      ld_data   = (head_mode == MAC_MODE_NONE && !head_acc) ? '0 : head_c;
      ld_nb     = BC_W'(mac_beats(head_mode, head_acc, NB_FULL));
   end

   // Occupancy counts the frame in the shift register too, so a credit is
   // returned only once its last beat has left; that frees a slot for a
   // same-cycle capture even when storage is otherwise full.
   always_comb begin
      busy          = (state_q == ST_SEND);
      last_beat     = (beat_cnt_q == nb_q - BC_W'(1));
      frame_done    = busy & out_ready_i & last_beat;
      occ           = OCC_W'(fifo_count) + OCC_W'(busy);
      drop          = cap_now & (occ >= OCC_W'(DEPTH)) & ~frame_done;
      fifo_push     = cap_now & ~drop;
      overflow_d    = overflow_q | drop;
      issue_ready_o = (occ + inflight) < OCC_W'(DEPTH);
   end

   // Serializer next state: load from FIFO, shift out per handshake, chain frames without a bubble
   always_comb begin
      state_d    = state_q;
      shreg_d    = shreg_q;
      beat_cnt_d = beat_cnt_q;
      nb_d       = nb_q;
      mode_d     = mode_q;
      fifo_pop   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (!fifo_empty) begin
               fifo_pop   = 1'b1;
               shreg_d    = ld_data;
               beat_cnt_d = '0;
               nb_d       = ld_nb;
               mode_d     = head_mode;
               state_d    = ST_SEND;
            end
         end
         ST_SEND: begin
            if (out_ready_i) begin
               if (last_beat) begin
                  if (!fifo_empty) begin
                     fifo_pop   = 1'b1;
                     shreg_d    = ld_data;
                     beat_cnt_d = '0;
                     nb_d       = ld_nb;
                     mode_d     = head_mode;
                  end else begin
                     // Clear so idle outputs read as zero
                     shreg_d    = '0;
                     beat_cnt_d = '0;
                     nb_d       = '0;
                     mode_d     = '0;
                     state_d    = ST_IDLE;
                  end
               end else begin
                  shreg_d    = shreg_q >> MIN_W;
                  beat_cnt_d = beat_cnt_q + BC_W'(1);
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Serializer and sticky error registers; reset drops any partial frame
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= ST_IDLE;
         shreg_q    <= '0;
         beat_cnt_q <= '0;
         nb_q       <= '0;
         mode_q     <= '0;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         shreg_q    <= shreg_d;
         beat_cnt_q <= beat_cnt_d;
         nb_q       <= nb_d;
         mode_q     <= mode_d;
         overflow_q <= overflow_d;
      end
   end

   // All outputs come straight from registers, so they stay stable across a stall
   assign out_valid_o    = busy;
   assign out_data_o     = shreg_q[MIN_W-1:0];
   assign out_first_o    = busy & (beat_cnt_q == '0);
   assign out_last_o     = busy & last_beat;
   assign out_mode_o     = mode_q;
   assign overflow_err_o = overflow_q;

endmodule

// File: tb/tb_mac_result_drain.sv
// Directed bench for mac_result_drain with a beat scoreboard.
// Stimulus pushes hand-computed beats; a monitor pops on every handshake.
// Stalls are checked for output stability; reset mid-frame flushes expectations.
module tb_mac_result_drain;

   localparam int MIN_W  = 8;
   localparam int ACC_W  = 48;
   localparam int CONF_W = 3;
   localparam int LAT    = 1;
   localparam int DEPTH  = 4;

   logic              clk_i = 1'b0;
   logic              rst_ni;
   logic              issue_valid_i;
   logic              issue_last_i;
   logic [CONF_W-1:0] issue_cfg_i;
   logic [ACC_W-1:0]  mac_c_i;
   logic              issue_ready_o;
   logic              out_valid_o;
   logic              out_ready_i;
   logic [MIN_W-1:0]  out_data_o;
   logic              out_first_o;
   logic              out_last_o;
   logic [1:0]        out_mode_o;
   logic              overflow_err_o;

   always #5 clk_i = ~clk_i;

   mac_result_drain #(
      .MIN_W  (MIN_W),
      .ACC_W  (ACC_W),
      .CONF_W (CONF_W),
      .LAT    (LAT),
      .DEPTH  (DEPTH)
   ) dut (
      .clk_i          (clk_i),
      .rst_ni         (rst_ni),
      .issue_valid_i  (issue_valid_i),
      .issue_last_i   (issue_last_i),
      .issue_cfg_i    (issue_cfg_i),
      .mac_c_i        (mac_c_i),
      .issue_ready_o  (issue_ready_o),
      .out_valid_o    (out_valid_o),
      .out_ready_i    (out_ready_i),
      .out_data_o     (out_data_o),
      .out_first_o    (out_first_o),
      .out_last_o     (out_last_o),
      .out_mode_o     (out_mode_o),
      .overflow_err_o (overflow_err_o)
   );

   // {data, first, last, mode}
   typedef logic [11:0] beat_t;

   beat_t            exp_q [$];
   int               n_cmp = 0;
   int               n_bad = 0;
   int               cyc = 0;
   logic [ACC_W-1:0] c_prev = '0;
   bit               contig_chk = 1'b0;
   int               last_hs = -1;
   bit               stall_prev = 1'b0;
   beat_t            held;
   beat_t            mon_cur;

   always @(posedge clk_i) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", name, act, req);
      end
   endtask

   task automatic exp_beat(input logic [7:0] d, input logic f, input logic l, input logic [1:0] m);
      exp_q.push_back({d, f, l, m});
   endtask

   // One cycle of issue; mac_c carries the C belonging to the previous cycle's issue (LAT=1)
   task automatic drive(input logic v, input logic last, input logic [2:0] cfg, input logic [47:0] c);
      @(posedge clk_i);
      #1;
      issue_valid_i = v;
      issue_last_i  = last;
      issue_cfg_i   = cfg;
      mac_c_i       = c_prev;
      c_prev        = v ? c : '0;
   endtask

   task automatic idle(input int n);
      repeat (n) drive(1'b0, 1'b0, 3'b000, 48'h0);
   endtask

   task automatic drain(input string name);
      for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(negedge clk_i);
      idle(4);
      check(name, exp_q.size(), 0);
   endtask

   // Monitor: compare each accepted beat, and check outputs hold across stalls
   initial begin
      forever begin
         @(negedge clk_i);
         if (!rst_ni) begin
            stall_prev = 1'b0;
         end else begin
            mon_cur = {out_data_o, out_first_o, out_last_o, out_mode_o};
            if (stall_prev) begin
               check("stall_valid", out_valid_o, 1);
               check("stall_hold", mon_cur, held);
            end
            if (out_valid_o && out_ready_i) begin
               if (exp_q.size() == 0) begin
                  n_cmp++;
                  n_bad++;
                  $display("FAIL unexpected_beat: got %0h, expected no beat", mon_cur);
               end else begin
                  check("beat", mon_cur, exp_q.pop_front());
               end
               if (contig_chk) begin
                  if (last_hs >= 0) check("contiguous_gap", cyc - last_hs, 1);
                  last_hs = cyc;
               end
               stall_prev = 1'b0;
            end else if (out_valid_o) begin
               stall_prev = 1'b1;
               held = mon_cur;
            end else begin
               stall_prev = 1'b0;
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got no finish, expected finish");
      $fatal(1);
   end

   initial begin
      rst_ni        = 1'b0;
      issue_valid_i = 1'b0;
      issue_last_i  = 1'b0;
      issue_cfg_i   = '0;
      mac_c_i       = '0;
      out_ready_i   = 1'b1;
      #1;
      check("rst_valid", out_valid_o, 0);
      check("rst_first", out_first_o, 0);
      check("rst_last", out_last_o, 0);
      check("rst_data", out_data_o, 0);
      check("rst_mode", out_mode_o, 0);
      check("rst_issue_ready", issue_ready_o, 1);
      check("rst_overflow", overflow_err_o, 0);
      repeat (2) @(posedge clk_i);
      #1;
      rst_ni = 1'b1;

      // 1: SINGLE frame, then mode 11 single zero beat
      exp_beat(8'h34, 1, 0, 2'd0);
      exp_beat(8'h12, 0, 1, 2'd0);
      drive(1, 0, 3'b000, 48'h000000001234);
      idle(1);
      drain("t1_single_drain");
      exp_beat(8'h00, 1, 1, 2'd3);
      drive(1, 0, 3'b011, 48'h00000000FFFF);
      idle(1);
      drain("t1_mode3_drain");

      // 2: three DUAL frames back-to-back, beats must be contiguous
      contig_chk = 1'b1;
      last_hs    = -1;
      exp_beat(8'hA3, 1, 0, 2'd1); exp_beat(8'hA2, 0, 0, 2'd1); exp_beat(8'hA1, 0, 1, 2'd1);
      exp_beat(8'hB3, 1, 0, 2'd1); exp_beat(8'hB2, 0, 0, 2'd1); exp_beat(8'hB1, 0, 1, 2'd1);
      exp_beat(8'hC3, 1, 0, 2'd1); exp_beat(8'hC2, 0, 0, 2'd1); exp_beat(8'hC1, 0, 1, 2'd1);
      drive(1, 0, 3'b001, 48'h000000A1A2A3);
      drive(1, 0, 3'b001, 48'h000000B1B2B3);
      drive(1, 0, 3'b001, 48'h000000C1C2C3);
      idle(1);
      drain("t2_dual_drain");
      contig_chk = 1'b0;

      // 3: accumulation window of 4, only the last C is emitted as 6 beats
      exp_beat(8'h0F, 1, 0, 2'd0); exp_beat(8'h0E, 0, 0, 2'd0); exp_beat(8'h0D, 0, 0, 2'd0);
      exp_beat(8'h0C, 0, 0, 2'd0); exp_beat(8'h0B, 0, 0, 2'd0); exp_beat(8'h0A, 0, 1, 2'd0);
      drive(1, 0, 3'b100, 48'h111111111111);
      drive(1, 0, 3'b100, 48'h222222222222);
      drive(1, 0, 3'b100, 48'h333333333333);
      drive(1, 1, 3'b100, 48'h0A0B0C0D0E0F);
      idle(1);
      drain("t3_acc_drain");

      // 4: fill credits with the sink stalled, force a 5th issue to overflow
      out_ready_i = 1'b0;
      exp_beat(8'h2A, 1, 0, 2'd0); exp_beat(8'h1A, 0, 1, 2'd0);
      exp_beat(8'h2B, 1, 0, 2'd0); exp_beat(8'h1B, 0, 1, 2'd0);
      exp_beat(8'h2C, 1, 0, 2'd0); exp_beat(8'h1C, 0, 1, 2'd0);
      exp_beat(8'h2D, 1, 0, 2'd0); exp_beat(8'h1D, 0, 1, 2'd0);
      drive(1, 0, 3'b000, 48'h1A2A);
      drive(1, 0, 3'b000, 48'h1B2B);
      drive(1, 0, 3'b000, 48'h1C2C);
      check("t4_ready_before_4th", issue_ready_o, 1);
      drive(1, 0, 3'b000, 48'h1D2D);
      idle(1);
      check("t4_ready_after_4th", issue_ready_o, 0);
      check("t4_no_overflow_yet", overflow_err_o, 0);
      drive(1, 0, 3'b000, 48'h1E2E);
      idle(2);
      check("t4_overflow_set", overflow_err_o, 1);
      check("t4_ready_still_low", issue_ready_o, 0);
      out_ready_i = 1'b1;
      drain("t4_four_frames_drain");
      check("t4_overflow_sticky", overflow_err_o, 1);
      check("t4_ready_restored", issue_ready_o, 1);

      // 5: QUAD frame with out_ready toggling
      exp_beat(8'h55, 1, 0, 2'd2); exp_beat(8'h44, 0, 0, 2'd2); exp_beat(8'h33, 0, 0, 2'd2);
      exp_beat(8'h22, 0, 0, 2'd2); exp_beat(8'h11, 0, 1, 2'd2);
      drive(1, 0, 3'b010, 48'h001122334455);
      idle(1);
      for (int i = 0; i < 14; i++) begin
         idle(1);
         out_ready_i = ~out_ready_i;
      end
      out_ready_i = 1'b1;
      drain("t5_quad_drain");

      // 6: reset in the middle of a 6-beat frame (beat index 2 presented)
      out_ready_i = 1'b0;
      exp_beat(8'h11, 1, 0, 2'd0); exp_beat(8'h22, 0, 0, 2'd0); exp_beat(8'h33, 0, 0, 2'd0);
      exp_beat(8'h44, 0, 0, 2'd0); exp_beat(8'h55, 0, 0, 2'd0); exp_beat(8'h66, 0, 1, 2'd0);
      drive(1, 1, 3'b100, 48'h665544332211);
      idle(1);
      for (int i = 0; i < 20 && !out_valid_o; i++) idle(1);
      check("t6_frame_started", out_valid_o, 1);
      out_ready_i = 1'b1;
      idle(2);
      out_ready_i = 1'b0;
      check("t6_beat2_data", out_data_o, 8'h33);
      #1;
      rst_ni = 1'b0;
      #1;
      exp_q.delete();
      check("t6_rst_valid", out_valid_o, 0);
      check("t6_rst_first", out_first_o, 0);
      check("t6_rst_last", out_last_o, 0);
      check("t6_rst_data", out_data_o, 0);
      check("t6_rst_mode", out_mode_o, 0);
      check("t6_rst_issue_ready", issue_ready_o, 1);
      check("t6_rst_overflow", overflow_err_o, 0);
      @(posedge clk_i);
      #1;
      rst_ni      = 1'b1;
      out_ready_i = 1'b1;
      idle(10);
      check("t6_no_stale_valid", out_valid_o, 0);

      // Normal operation resumes after reset
      exp_beat(8'hEF, 1, 0, 2'd0);
      exp_beat(8'hBE, 0, 1, 2'd0);
      drive(1, 0, 3'b000, 48'h00000000BEEF);
      idle(1);
      drain("t6_resume_drain");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
